// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-side bundle of the 7-segment scan controller: load handshake, BCD value and
// the registered anode/segment drive.
interface seven_seg_scan_ctrl_if #(
    parameter int unsigned DIGITS = 4
) ();
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic                  lz_blank;
    logic                  ready;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;

    modport master (
        output load, value, lz_blank,
        input  ready, an, seg
    );

    modport slave (
        input  load, value, lz_blank,
        output ready, an, seg
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with per-slot blank gap, leading-zero
// suppression and a load handshake that only swaps the shown value on frame boundaries.
module seven_seg_scan_ctrl #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    seven_seg_scan_ctrl_if.slave  bus
);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned VAL_W = 4 * DIGITS;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    function automatic logic [6:0] dec7(input logic [3:0] code);
        case (code)
            4'd0:    dec7 = 7'b0111111;
            4'd1:    dec7 = 7'b0000110;
            4'd2:    dec7 = 7'b1011011;
            4'd3:    dec7 = 7'b1001111;
            4'd4:    dec7 = 7'b1100110;
            4'd5:    dec7 = 7'b1101101;
            4'd6:    dec7 = 7'b1111101;
            4'd7:    dec7 = 7'b0000111;
            4'd8:    dec7 = 7'b1111111;
            4'd9:    dec7 = 7'b1101111;
            default: dec7 = 7'b0000000;
        endcase
    endfunction

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [VAL_W-1:0]   r_shadow;
    logic [VAL_W-1:0]   r_pend_val;
    logic               r_pending;
    logic               r_ready;
    logic [DIGITS-1:0]  r_an;
    logic [6:0]         r_seg;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_wrap;
    logic               w_frame_end;
    logic [3:0]         w_code;
    logic               w_hi_zero;
    logic [DIGITS-1:0]  w_an_nxt;
    logic [6:0]         w_seg_nxt;

    // Slot timing, phase FSM and the drive values for the upcoming cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_wrap      = (r_cnt == CNT_W'(PRESCALE - 1));
        w_frame_end = w_wrap && (r_idx == IDX_W'(DIGITS - 1));
        w_code      = 4'd0;
        w_hi_zero   = 1'b1;
        w_an_nxt    = '0;
        w_seg_nxt   = '0;

        if (w_wrap) begin
            w_cnt_nxt = '0;
            w_idx_nxt = w_frame_end ? '0 : r_idx + IDX_W'(1);
        end

        case (r_state)
            ST_BLANK: if (w_cnt_nxt == CNT_W'(BLANK_CYCLES)) w_state_nxt = ST_SHOW;
            ST_SHOW:  if (w_wrap)                            w_state_nxt = ST_BLANK;
            default:                                         w_state_nxt = ST_BLANK;
        endcase

        // Digit to show next, and whether it and every higher digit are zero.
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (IDX_W'(i) == w_idx_nxt) w_code = r_shadow[4*i +: 4];
            if ((i >= int'(w_idx_nxt)) && (r_shadow[4*i +: 4] != 4'd0)) w_hi_zero = 1'b0;
        end

        if (w_state_nxt == ST_SHOW) begin
            w_an_nxt = DIGITS'(1) << w_idx_nxt;
            if (!(bus.lz_blank && (w_idx_nxt != '0) && w_hi_zero)) w_seg_nxt = dec7(w_code);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BLANK;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shadow   <= '0;
            r_pend_val <= '0;
            r_pending  <= 1'b0;
            r_ready    <= 1'b1;
            r_an       <= '0;
            r_seg      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
            // pending is checked before a same-edge accept, so that accept waits a frame
            if (w_frame_end && r_pending) begin
                r_shadow  <= r_pend_val;
                r_pending <= 1'b0;
                r_ready   <= 1'b1;
            end else if (bus.load && r_ready) begin
                r_pend_val <= bus.value;
                r_pending  <= 1'b1;
                r_ready    <= 1'b0;
            end
        end
    end

    assign bus.ready = r_ready;
    assign bus.an    = r_an;
    assign bus.seg   = r_seg;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl at DIGITS=4, PRESCALE=8, BLANK_CYCLES=2;
// positions are cycles since reset release (frame*32 + digit*8 + count).
module tb_seven_seg_scan_ctrl;
    localparam int unsigned DIGITS       = 4;
    localparam int unsigned PRESCALE     = 8;
    localparam int unsigned BLANK_CYCLES = 2;

    typedef struct packed {
        logic [15:0] p;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seven_seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

    seven_seg_scan_ctrl #(
        .DIGITS      (DIGITS),
        .PRESCALE    (PRESCALE),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          pos    = 0;
    int          ld_pos = -1;
    logic [15:0] ld_val = 16'h0000;

    // One clock: drives the scheduled load for this cycle's edge, samples 1 time unit later.
    task automatic tick();
        if (pos == ld_pos) begin
            bus.load  = 1'b1;
            bus.value = ld_val;
        end else begin
            bus.load = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        pos++;
    endtask

    task automatic goto(input int p);
        while (pos < p) tick();
    endtask

    task automatic test_reset();
        vec_t t [8];
        t = '{{16'd0,  4'b0000, 7'b0000000, 1'b1},
              {16'd1,  4'b0000, 7'b0000000, 1'b1},
              {16'd2,  4'b0001, 7'b0111111, 1'b1},
              {16'd5,  4'b0001, 7'b0111111, 1'b1},
              {16'd7,  4'b0001, 7'b0111111, 1'b1},
              {16'd8,  4'b0000, 7'b0000000, 1'b1},
              {16'd9,  4'b0000, 7'b0000000, 1'b1},
              {16'd10, 4'b0010, 7'b0111111, 1'b1}};
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.an, bus.seg, bus.ready} !== {4'b0000, 7'b0000000, 1'b1}) begin
            errors++;
            $display("FAIL reset_hold: an=%b seg=%b ready=%b, expected an=0000 seg=0000000 ready=1",
                     bus.an, bus.seg, bus.ready);
        end
        rst = 1'b0;
        pos = 0;
        for (int k = 0; k < 8; k++) begin
            goto(int'(t[k].p));
            checks++;
            if ({bus.an, bus.seg, bus.ready} !== {t[k].an, t[k].seg, t[k].rdy}) begin
                errors++;
                $display("FAIL reset_scan pos=%0d: an=%b seg=%b ready=%b, expected an=%b seg=%b ready=%b",
                         pos, bus.an, bus.seg, bus.ready, t[k].an, t[k].seg, t[k].rdy);
            end
        end
    endtask

    task automatic test_load();
        vec_t t [8];
        t = '{{16'd36, 4'b0001, 7'b0111111, 1'b0},
              {16'd42, 4'b0010, 7'b0111111, 1'b0},
              {16'd63, 4'b1000, 7'b0111111, 1'b0},
              {16'd64, 4'b0000, 7'b0000000, 1'b1},
              {16'd66, 4'b0001, 7'b1100110, 1'b1},
              {16'd74, 4'b0010, 7'b1001111, 1'b1},
              {16'd82, 4'b0100, 7'b1011011, 1'b1},
              {16'd90, 4'b1000, 7'b0000110, 1'b1}};
        ld_pos = 35;
        ld_val = 16'h1234;
        for (int k = 0; k < 8; k++) begin
            goto(int'(t[k].p));
            checks++;
            if ({bus.an, bus.seg, bus.ready} !== {t[k].an, t[k].seg, t[k].rdy}) begin
                errors++;
                $display("FAIL load pos=%0d: an=%b seg=%b ready=%b, expected an=%b seg=%b ready=%b",
                         pos, bus.an, bus.seg, bus.ready, t[k].an, t[k].seg, t[k].rdy);
            end
        end
    endtask

    task automatic test_ignore_busy();
        vec_t t [7];
        t = '{{16'd100, 4'b0001, 7'b1100110, 1'b0},
              {16'd102, 4'b0001, 7'b1100110, 1'b0},
              {16'd127, 4'b1000, 7'b0000110, 1'b0},
              {16'd128, 4'b0000, 7'b0000000, 1'b1},
              {16'd130, 4'b0001, 7'b1100110, 1'b1},
              {16'd138, 4'b0010, 7'b1001111, 1'b1},
              {16'd157, 4'b1000, 7'b0000110, 1'b1}};
        ld_pos = 99;
        ld_val = 16'h1234;
        for (int k = 0; k < 7; k++) begin
            goto(int'(t[k].p));
            if (pos == 100) begin
                ld_pos = 101;
                ld_val = 16'h9999;
            end
            checks++;
            if ({bus.an, bus.seg, bus.ready} !== {t[k].an, t[k].seg, t[k].rdy}) begin
                errors++;
                $display("FAIL ignore_busy pos=%0d: an=%b seg=%b ready=%b, expected an=%b seg=%b ready=%b",
                         pos, bus.an, bus.seg, bus.ready, t[k].an, t[k].seg, t[k].rdy);
            end
        end
    endtask

    task automatic test_lz_blank();
        vec_t t [7];
        t = '{{16'd170, 4'b0010, 7'b1001111, 1'b0},
              {16'd194, 4'b0001, 7'b0111111, 1'b1},
              {16'd202, 4'b0010, 7'b0000111, 1'b1},
              {16'd210, 4'b0100, 7'b0000000, 1'b1},
              {16'd219, 4'b1000, 7'b0000000, 1'b1},
              {16'd220, 4'b1000, 7'b0111111, 1'b1},
              {16'd242, 4'b0100, 7'b0111111, 1'b1}};
        bus.lz_blank = 1'b1;
        ld_pos = 168;
        ld_val = 16'h0070;
        for (int k = 0; k < 7; k++) begin
            goto(int'(t[k].p));
            checks++;
            if ({bus.an, bus.seg, bus.ready} !== {t[k].an, t[k].seg, t[k].rdy}) begin
                errors++;
                $display("FAIL lz_blank pos=%0d lz=%b: an=%b seg=%b ready=%b, expected an=%b seg=%b ready=%b",
                         pos, bus.lz_blank, bus.an, bus.seg, bus.ready, t[k].an, t[k].seg, t[k].rdy);
            end
            if (pos == 219) bus.lz_blank = 1'b0;
        end
    endtask

    task automatic test_wrap_load();
        vec_t t [9];
        t = '{{16'd256, 4'b0000, 7'b0000000, 1'b0},
              {16'd258, 4'b0001, 7'b0111111, 1'b0},
              {16'd266, 4'b0010, 7'b0000111, 1'b0},
              {16'd287, 4'b1000, 7'b0111111, 1'b0},
              {16'd288, 4'b0000, 7'b0000000, 1'b1},
              {16'd290, 4'b0001, 7'b1101101, 1'b1},
              {16'd298, 4'b0010, 7'b0000000, 1'b1},
              {16'd306, 4'b0100, 7'b1011011, 1'b1},
              {16'd314, 4'b1000, 7'b0000110, 1'b1}};
        ld_pos = 255;
        ld_val = 16'h12A5;
        for (int k = 0; k < 9; k++) begin
            goto(int'(t[k].p));
            checks++;
            if ({bus.an, bus.seg, bus.ready} !== {t[k].an, t[k].seg, t[k].rdy}) begin
                errors++;
                $display("FAIL wrap_load pos=%0d: an=%b seg=%b ready=%b, expected an=%b seg=%b ready=%b",
                         pos, bus.an, bus.seg, bus.ready, t[k].an, t[k].seg, t[k].rdy);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t t [5];
        t = '{{16'd0,  4'b0000, 7'b0000000, 1'b1},
              {16'd26, 4'b1000, 7'b0111111, 1'b1},
              {16'd32, 4'b0000, 7'b0000000, 1'b1},
              {16'd34, 4'b0001, 7'b0111111, 1'b1},
              {16'd58, 4'b1000, 7'b0111111, 1'b1}};
        ld_pos = 328;
        ld_val = 16'h8888;
        goto(329);
        checks++;
        if ({bus.an, bus.seg, bus.ready} !== {4'b0000, 7'b0000000, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_pending: an=%b seg=%b ready=%b, expected an=0000 seg=0000000 ready=0",
                     bus.an, bus.seg, bus.ready);
        end
        goto(340);
        checks++;
        if ({bus.an, bus.seg, bus.ready} !== {4'b0100, 7'b1011011, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_show: an=%b seg=%b ready=%b, expected an=0100 seg=1011011 ready=0",
                     bus.an, bus.seg, bus.ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pos = 0;
        ld_pos = -1;
        for (int k = 0; k < 5; k++) begin
            goto(int'(t[k].p));
            checks++;
            if ({bus.an, bus.seg, bus.ready} !== {t[k].an, t[k].seg, t[k].rdy}) begin
                errors++;
                $display("FAIL reset_mid pos=%0d: an=%b seg=%b ready=%b, expected an=%b seg=%b ready=%b",
                         pos, bus.an, bus.seg, bus.ready, t[k].an, t[k].seg, t[k].rdy);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.value    = 16'h0000;
        bus.lz_blank = 1'b0;
        test_reset();
        test_load();
        test_ignore_busy();
        test_lz_blank();
        test_wrap_load();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at pos=%0d", pos);
        $fatal(1, "watchdog");
    end
endmodule
